// File: rtl/de10_disp_ctl_if.sv
// de10_disp_ctl_if
// Purpose: groups the two requester ports of the DE10 display controller.
//   The PDP-8 IOT register port and the time-of-day handshake share one bundle.
// Signals:
//   iot_sel    IOT device select, one cycle per IOT
//   iot_we     write strobe, qualified by iot_sel
//   iot_addr   register select (IOT low octal digit)
//   iot_wdata  12-bit write data
//   iot_rdata  12-bit read data (combinational)
//   time_valid time word offered
//   time_bcd   packed BCD {H1,H0,M1,M0,S1,S0}
//   time_ready controller accepts the time word
// Modports: master = requester side, slave = controller side.
interface de10_disp_ctl_if;
    logic        iot_sel;
    logic        iot_we;
    logic [2:0]  iot_addr;
    logic [11:0] iot_wdata;
    logic [11:0] iot_rdata;
    logic        time_valid;
    logic [23:0] time_bcd;
    logic        time_ready;

    modport master (
        output iot_sel, iot_we, iot_addr, iot_wdata, time_valid, time_bcd,
        input  iot_rdata, time_ready
    );

    modport slave (
        input  iot_sel, iot_we, iot_addr, iot_wdata, time_valid, time_bcd,
        output iot_rdata, time_ready
    );
endinterface

// File: rtl/de10_disp_ctl.sv
// de10_disp_ctl
// Purpose: owns the six DE10 seven-segment digit registers and the LED
//   register. The PDP-8 IOT port and a time-of-day sequencer share write
//   access to the digits; CPU writes always win. The sequencer captures a
//   packed BCD time word and writes one decoded digit per cycle, hex0 first.
// Ports:
//   clk        system clock (50 MHz)
//   rst_n      asynchronous active-low reset
//   bus        de10_disp_ctl_if.slave: IOT register port + time handshake
//   busy       sequencer is writing digits
//   hex0..hex5 active-low segment drive
//   leds       LED register (never blanked)
module de10_disp_ctl #(
    parameter logic [47:0] RST_DISP  = 48'h73_5E_73_40_7F_79,
    parameter logic [7:0]  BLANK_SEG = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    de10_disp_ctl_if.slave        bus,
    output logic                  busy,
    output logic [7:0]            hex0,
    output logic [7:0]            hex1,
    output logic [7:0]            hex2,
    output logic [7:0]            hex3,
    output logic [7:0]            hex4,
    output logic [7:0]            hex5,
    output logic [11:0]           leds
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;

    logic [0:0]  state;
    logic [2:0]  idx;
    logic [23:0] shadow;
    logic [1:0]  mode;
    logic [7:0]  disp [0:5];

    logic        cpu_wr;
    logic        cpu_disp_wr;
    logic        seq_wr;
    logic [3:0]  nibble;
    logic [7:0]  seq_seg;

    // Nibble to active-high segments; A-F shown as hex since time nibbles
    // are not range-checked.
    function automatic logic [7:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 8'h3F;
            4'h1: decode = 8'h06;
            4'h2: decode = 8'h5B;
            4'h3: decode = 8'h4F;
            4'h4: decode = 8'h66;
            4'h5: decode = 8'h6D;
            4'h6: decode = 8'h7D;
            4'h7: decode = 8'h07;
            4'h8: decode = 8'h7F;
            4'h9: decode = 8'h67;
            4'hA: decode = 8'h77;
            4'hB: decode = 8'h7C;
            4'hC: decode = 8'h39;
            4'hD: decode = 8'h5E;
            4'hE: decode = 8'h79;
            default: decode = 8'h71;
        endcase
    endfunction

    assign cpu_wr      = bus.iot_sel & bus.iot_we;
    assign cpu_disp_wr = cpu_wr & (bus.iot_addr < 3'd6);
    assign busy        = (state == LOAD);
    // Any CPU digit write stalls the sequencer for that cycle, even one
    // aimed at a different digit, so the two never write in the same cycle.
    assign seq_wr      = busy & ~cpu_disp_wr;
    assign bus.time_ready = (state == IDLE) & mode[0];

    always_comb begin
        nibble = 4'h0;
        case (idx)
            3'd0: nibble = shadow[3:0];
            3'd1: nibble = shadow[7:4];
            3'd2: nibble = shadow[11:8];
            3'd3: nibble = shadow[15:12];
            3'd4: nibble = shadow[19:16];
            3'd5: nibble = shadow[23:20];
            default: nibble = 4'h0;
        endcase
    end

    assign seq_seg = decode(nibble);

    // Digit registers: CPU write has priority over the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                disp[i] <= RST_DISP[8*i +: 8];
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (cpu_disp_wr && bus.iot_addr == 3'(i)) begin
                    disp[i] <= bus.iot_wdata[7:0];
                end else if (seq_wr && idx == 3'(i)) begin
                    disp[i] <= seq_seg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 2'b00;
            leds <= 12'h000;
        end else if (cpu_wr) begin
            if (bus.iot_addr == 3'd6) begin
                mode <= bus.iot_wdata[1:0];
            end
            if (bus.iot_addr == 3'd7) begin
                leds <= bus.iot_wdata;
            end
        end
    end

    // Sequencer: capture the word on handshake, then walk idx 0..5. Clearing
    // mode[0] mid-sequence does not abort; it only gates the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= 3'd0;
            shadow <= 24'h000000;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.time_valid && bus.time_ready) begin
                        shadow <= bus.time_bcd;
                        idx    <= 3'd0;
                        state  <= LOAD;
                    end
                end
                default: begin
                    if (seq_wr) begin
                        if (idx == 3'd5) begin
                            idx   <= 3'd0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign hex0 = mode[1] ? ~BLANK_SEG : ~disp[0];
    assign hex1 = mode[1] ? ~BLANK_SEG : ~disp[1];
    assign hex2 = mode[1] ? ~BLANK_SEG : ~disp[2];
    assign hex3 = mode[1] ? ~BLANK_SEG : ~disp[3];
    assign hex4 = mode[1] ? ~BLANK_SEG : ~disp[4];
    assign hex5 = mode[1] ? ~BLANK_SEG : ~disp[5];

    always_comb begin
        bus.iot_rdata = 12'h000;
        if (bus.iot_sel) begin
            case (bus.iot_addr)
                3'd0: bus.iot_rdata = {4'o0, disp[0]};
                3'd1: bus.iot_rdata = {4'o0, disp[1]};
                3'd2: bus.iot_rdata = {4'o0, disp[2]};
                3'd3: bus.iot_rdata = {4'o0, disp[3]};
                3'd4: bus.iot_rdata = {4'o0, disp[4]};
                3'd5: bus.iot_rdata = {4'o0, disp[5]};
                3'd6: bus.iot_rdata = {9'b0, busy, mode};
                default: bus.iot_rdata = leds;
            endcase
        end
    end

endmodule
